imem_loader: RTL and testbench

- Writable 32-word instruction memory with a byte-serial program loader (write side) and a combinational fetch read port.
- The loader receives a program as a big-endian byte stream over a valid/ready handshake, assembles 32-bit words and writes them to consecutive word addresses starting at 0.
- The read port is a drop-in for the CPU fetch path: byte address in, instruction word out, no clock.

---
 rtl/imem_loader_if.sv | 31 +++
 rtl/imem_loader.sv | 147 ++++++++++++++
 tb/tb_imem_loader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
// Byte-stream handshake between a program source and the imem_loader.
//   ByteIn    : program byte, big-endian order within each 32-bit word
//   ByteValid : ByteIn is valid this cycle
//   ByteLast  : ByteIn is the final byte of the program
//   ByteReady : loader accepts a byte this cycle (registered, state only)
// A byte transfers on a rising clock edge where ByteValid && ByteReady.
// ---------------------------------------------------------------------------
interface imem_loader_if;
    logic [7:0] ByteIn;
    logic       ByteValid;
    logic       ByteLast;
    logic       ByteReady;

    // Program source side.
    modport master (
        output ByteIn,
        output ByteValid,
        output ByteLast,
        input  ByteReady
    );

    // Loader side.
    modport slave (
        input  ByteIn,
        input  ByteValid,
        input  ByteLast,
        output ByteReady
    );
endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// 2**AW-word instruction memory with a byte-serial program loader and a
// combinational fetch port.
//   CLK       : system clock, rising edge
//   RST_n     : asynchronous active-low reset; clears state and memory
//   Start     : one-cycle pulse; begins or restarts a load at word 0
//   bus       : byte-stream handshake (imem_loader_if.slave)
//   Addr      : fetch byte address; word index = Addr[AW+1:2]
//   Inst      : instruction word at the indexed address, combinational
//   Loading   : high while in LOAD
//   Done      : high while in DONE
//   WordCount : words written by the current load, 0..2**AW
// Bytes are packed big-endian: the first byte of each word lands in
// [31:24]. A word is written on its 4th byte, or early on ByteLast with the
// unfilled low lanes written as zero. A full memory ends the load instead
// of wrapping back to word 0.
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic           CLK,
    input  logic           RST_n,
    input  logic           Start,
    imem_loader_if.slave   bus,
    input  logic [31:0]    Addr,
    output logic [DW-1:0]  Inst,
    output logic           Loading,
    output logic           Done,
    output logic [AW:0]    WordCount
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [DW-1:0]   mem_q [DEPTH];
    logic [DW-1:0]   asm_q;      // partially assembled word
    logic [1:0]      idx_q;      // byte index within the current word
    logic [AW:0]     count_q;    // words written; low AW bits are the write pointer
    logic            ready_q;
    logic            loading_q;
    logic            done_q;

    logic [AW-1:0]   wr_ptr;
    logic [DW-1:0]   asm_next;
    logic            accept;
    logic            word_end;

    assign wr_ptr = count_q[AW-1:0];
    assign accept = bus.ByteValid && ready_q;
    assign word_end = (idx_q == 2'd3) || bus.ByteLast;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        asm_next = asm_q;
        asm_next = asm_q | ({bus.ByteIn, {(DW-8){1'b0}}} >> {idx_q, 3'b000});
    end

    // Single-process FSM: state, datapath and the registered status outputs
    // all update together, so ByteReady/Loading/Done track state exactly.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= S_IDLE;
            asm_q     <= '0;
            idx_q     <= '0;
            count_q   <= '0;
            ready_q   <= 1'b0;
            loading_q <= 1'b0;
            done_q    <= 1'b0;
            // NOTE: the memory is deliberately in the reset domain: a reset
            // must leave a known all-zero program, so it is built from flops
            // rather than an inferred RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        state_q   <= S_LOAD;
                        asm_q     <= '0;
                        idx_q     <= '0;
                        count_q   <= '0;
                        ready_q   <= 1'b1;
                        loading_q <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (Start) begin
                        // Restart wins over a byte accepted in the same cycle.
                        asm_q   <= '0;
                        idx_q   <= '0;
                        count_q <= '0;
                    end else if (accept) begin
                        if (word_end) begin
                            mem_q[wr_ptr] <= asm_next;
                            asm_q         <= '0;
                            idx_q         <= '0;
                            count_q       <= count_q + 1'b1;
                            if (bus.ByteLast || (wr_ptr == AW'(DEPTH - 1))) begin
                                state_q   <= S_DONE;
                                ready_q   <= 1'b0;
                                loading_q <= 1'b0;
                                done_q    <= 1'b1;
                            end
                        end else begin
                            asm_q <= asm_next;
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end

                default: begin
                    state_q   <= S_IDLE;
                    ready_q   <= 1'b0;
                    loading_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    // Fetch port: no write bypass, a word changes only at its write edge.
    assign Inst = mem_q[Addr[AW+1:2]];

    // Byte-offset and upper address bits are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^{Addr[31:AW+2], Addr[1:0]};

    assign bus.ByteReady = ready_q;
    assign Loading       = loading_q;
    assign Done          = done_q;
    assign WordCount     = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. The reference model treats a load as
// a stream of accepted bytes gathered into a queue; each full (or final)
// group becomes one big-endian word stored at the next word slot.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        Start;
    logic [31:0] Addr;
    logic [31:0] Inst;
    logic        Loading;
    logic        Done;
    logic [5:0]  WordCount;

    imem_loader_if bus ();

    imem_loader #(.AW(AW), .DW(32)) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .Start     (Start),
        .bus       (bus),
        .Addr      (Addr),
        .Inst      (Inst),
        .Loading   (Loading),
        .Done      (Done),
        .WordCount (WordCount)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    bit [31:0] m_mem [DEPTH];
    bit        m_loading;
    bit        m_done;
    int        m_count;
    bit [7:0]  m_part [$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_loading = 0;
        m_done    = 0;
        m_count   = 0;
        m_part.delete();
    endtask

    task automatic model_start();
        m_loading = 1;
        m_done    = 0;
        m_count   = 0;
        m_part.delete();
    endtask

    task automatic model_accept(input bit [7:0] b, input bit last,
                                output bit wrote, output int widx);
        bit [31:0] w;
        wrote = 0;
        widx  = 0;
        m_part.push_back(b);
        if (m_part.size() == 4 || last) begin
            w = '0;
            for (int i = 0; i < m_part.size(); i++)
                w = w | (32'(m_part[i]) << (24 - 8 * i));
            m_mem[m_count] = w;
            widx  = m_count;
            wrote = 1;
            m_count++;
            m_part.delete();
            if (last || m_count == DEPTH) begin
                m_loading = 0;
                m_done    = 1;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] word_addr(input int idx);
        logic [31:0] a;
        a      = $urandom();
        a[6:2] = 5'(idx);
        return a;
    endfunction

    task automatic check_status(input string tag);
        check({tag, ".ready"},   32'(bus.ByteReady), 32'(m_loading));
        check({tag, ".loading"}, 32'(Loading),       32'(m_loading));
        check({tag, ".done"},    32'(Done),          32'(m_done));
        check({tag, ".count"},   32'(WordCount),     32'(m_count));
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            Addr = word_addr(i);
            #1;
            check($sformatf("%s.w%0d", tag, i), Inst, m_mem[i]);
        end
    endtask

    task automatic idle_bus();
        bus.ByteValid = 1'b0;
        bus.ByteLast  = 1'b0;
    endtask

    task automatic do_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        model_start();
    endtask

    // Offer one byte (optionally after an idle cycle). Acceptance is predicted
    // from the model, and a completed word is checked right after its edge.
    task automatic send_byte(input bit [7:0] b, input bit last, input bit gap);
        bit will_accept;
        bit wrote;
        int widx;
        if (gap) begin
            idle_bus();
            tick();
        end
        bus.ByteIn    = b;
        bus.ByteLast  = last;
        bus.ByteValid = 1'b1;
        will_accept   = m_loading;
        tick();
        wrote = 0;
        if (will_accept) model_accept(b, last, wrote, widx);
        if (wrote) begin
            Addr = word_addr(widx);
            #1;
            check($sformatf("latency.w%0d", widx), Inst, m_mem[widx]);
            check("latency.count", 32'(WordCount), 32'(m_count));
            check("latency.done",  32'(Done),      32'(m_done));
        end
    endtask

    task automatic random_load(input int len, input bit gaps);
        do_start();
        for (int j = 0; j < len; j++)
            send_byte(8'($urandom()), j == len - 1, gaps && ($urandom_range(0, 1) == 1));
        idle_bus();
        tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] prog8 [8];
        RST_n         = 1'b0;
        Start         = 1'b0;
        Addr          = '0;
        bus.ByteIn    = '0;
        bus.ByteValid = 1'b0;
        bus.ByteLast  = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #3 RST_n = 1'b1;
        tick();

        // Reset state; bytes offered in IDLE are ignored.
        check_status("reset");
        check_mem("reset");
        send_byte(8'hFF, 1'b1, 1'b0);
        idle_bus();
        check_status("idle_ignore");
        check("idle_ignore.w0", Inst, 32'(0));

        // Two-word program, valid held high.
        prog8 = '{8'h20, 8'h01, 8'h00, 8'h08, 8'h34, 8'h02, 8'h00, 8'h0C};
        do_start();
        check_status("start");
        for (int j = 0; j < 8; j++) send_byte(prog8[j], j == 7, 1'b0);
        idle_bus();
        check_status("prog2");
        Addr = 32'd0; #1; check("prog2.w0", Inst, 32'h20010008);
        Addr = 32'd4; #1; check("prog2.w1", Inst, 32'h3402000C);
        tick();

        // Short program: last byte mid-word pads low lanes with zero.
        do_start();
        send_byte(8'hAD, 1'b0, 1'b0);
        send_byte(8'h02, 1'b1, 1'b0);
        idle_bus();
        check_status("short");
        Addr = 32'd0; #1; check("short.w0", Inst, 32'hAD020000);
        Addr = 32'd4; #1; check("short.w1", Inst, 32'h3402000C);

        // Full memory: 128 bytes without ByteLast, then a 129th offered.
        do_start();
        for (int j = 0; j < 4 * DEPTH; j++) send_byte(8'($urandom()), 1'b0, 1'b0);
        check_status("full");
        send_byte(8'h5A, 1'b0, 1'b0);
        idle_bus();
        check_status("full.extra");
        check_mem("full");

        // Restart mid-load with a coinciding valid byte, then toggled valid.
        do_start();
        for (int j = 0; j < 6; j++) send_byte(8'($urandom()), 1'b0, 1'b0);
        bus.ByteIn    = 8'hEE;
        bus.ByteValid = 1'b1;
        bus.ByteLast  = 1'b0;
        do_start();
        check_status("restart");
        send_byte(8'h11, 1'b0, 1'b1);
        send_byte(8'h22, 1'b0, 1'b1);
        send_byte(8'h33, 1'b0, 1'b1);
        send_byte(8'h44, 1'b0, 1'b1);
        idle_bus();
        tick();
        Addr = 32'd0; #1; check("restart.w0", Inst, 32'h11223344);
        check_status("restart.after");
        check_mem("restart");

        // Asynchronous reset mid-word while loading.
        send_byte(8'hAB, 1'b0, 1'b0);
        send_byte(8'hCD, 1'b0, 1'b0);
        idle_bus();
        Addr = 32'd0;
        #2 RST_n = 1'b0;
        #1;
        model_reset();
        check_status("async_rst");
        check("async_rst.w0", Inst, 32'h0);
        @(posedge CLK);
        #3 RST_n = 1'b1;
        tick();
        check_mem("async_rst");

        // Randomized programs, with and without valid gaps.
        for (int r = 0; r < 4; r++) begin
            random_load($urandom_range(1, 40), r[0]);
            check_status($sformatf("rand%0d", r));
            check_mem($sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
